pca_mem_arbiter: RTL and testbench
==================================

PCA_MEM_ARBITER -- requirements
Module: pca_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, constant-memory address width.
REQ-002 Parameter DATA_W, default 32, constant-memory data width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 h_req  in  1  host (constant loader) burst request, level, held until h_done.
REQ-006 h_rd_wr  in  1  host burst direction, 1=read, 0=write.
REQ-007 h_addr  in  ADDR_W  host burst start address.
REQ-008 h_len  in  4  host burst length code L; burst is L+1 beats (1..16).
REQ-009 h_wdata  in  DATA_W  host write data for the current beat.
REQ-010 h_ack  out  1  host beat issued to memory this cycle (write data consumed).
REQ-011 h_rvalid  out  1  rdata valid for host.
REQ-012 h_done  out  1  one-cycle pulse, host burst complete.
REQ-013 f_req  in  1  fitter read-burst request, level, held until f_done.
REQ-014 f_addr  in  ADDR_W  fitter burst start address.
REQ-015 f_len  in  4  fitter burst length code, same encoding as h_len.
REQ-016 f_ack, f_rvalid, f_done  out  1 each  fitter equivalents of h_ack, h_rvalid, h_done.
REQ-017 rdata  out  DATA_W  read data, shared by both requesters, qualified by h_rvalid/f_rvalid.
REQ-018 mem_en  out  1  memory access strobe, one access per cycle.
REQ-019 mem_rd_wr  out  1  1=read, 0=write.
REQ-020 mem_add  out  ADDR_W  memory address.
REQ-021 mem_wdata  out  DATA_W  memory write data.
REQ-022 mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.
REQ-023 busy  out  1  high whenever state is not IDLE.

Function
REQ-024 FSM states IDLE, BURST, DONE; IDLE->BURST on a granted request, BURST->DONE after last beat, DONE->IDLE unconditionally.
REQ-025 Requests sampled only in IDLE; grant latches owner, address, length and direction at that edge.
REQ-026 Fitter requests always read; fitter never causes a write.
REQ-027 Both requests in IDLE: round-robin, grant goes to requester not granted last; single request granted directly.
REQ-028 Request seen in IDLE at cycle t: beats on cycles t+1..t+L+1, mem_en high each, no gaps.
REQ-029 mem_add = start address on first beat, +1 per beat, wrapping modulo 2^ADDR_W.
REQ-030 Owner's ack high on every beat cycle; mem_wdata = h_wdata combinationally during host write beats, else 0.
REQ-031 Owner's rvalid high the cycle after each read beat; rdata = mem_rdata in that cycle, else 0.
REQ-032 Owner's done pulses in the DONE cycle (t+L+2), coinciding with the last rvalid for reads.
REQ-033 Earliest next burst beat is t+L+4; mem_en low in DONE and IDLE.
REQ-034 Request deassertion mid-burst ignored; burst completes at its latched length.
REQ-035 Non-owner's ack, rvalid, done stay 0 throughout.

Reset
REQ-036 reset forces IDLE and last-grant to host (fitter wins first tie); all outputs 0 next cycle.
REQ-037 reset mid-burst aborts: no further beats, no done, no rvalid for the aborted read.

Structure
REQ-038 Package pca_fit_pkg holds ADDR_W/DATA_W defaults, FSM state enum and owner enum {HOST, FIT}.
REQ-039 Sub-module pca_rr_arb: two-way round-robin arbiter with last-grant register.

Verification
REQ-040 Host write addr 0x10, len 3: mem_en cycles t+1..t+4, mem_add 0x10..0x13, mem_rd_wr=0, h_done at t+5.
REQ-041 Fitter read addr 0xFE, len 2: mem_add 0xFE,0xFF,0x00; f_rvalid t+2..t+4; f_done t+4.
REQ-042 h_req and f_req both high from reset, len 0, repeated 4 times: grants F,H,F,H.
REQ-043 f_req dropped mid-burst after 2 of 8 beats: all 8 beats issued, f_done pulses.
REQ-044 reset asserted on beat 3 of 16-beat host write: mem_en 0 next cycle, no h_done, busy 0.

Source files
------------

// File: rtl/pca_fit_pkg.sv
// Shared types and defaults for the constant-memory arbiter.
package pca_fit_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef enum logic {
      HOST = 1'b0,
      FIT  = 1'b1
   } owner_t;

endpackage

// File: rtl/pca_rr_arb.sv
// Two-way round-robin arbiter between host loader and fitter.
// A tie goes to whichever side did not win the previous grant.
module pca_rr_arb
   import pca_fit_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic h_req,
   input  logic f_req,
   input  logic en,
   output logic gnt_valid,
   output logic gnt_fit
);

   owner_t last_q;
   owner_t gnt_owner;

   // Pick the winner for this cycle from the live requests.
   always_comb begin
      gnt_valid = h_req | f_req;
      gnt_owner = HOST;
      if (h_req && f_req) begin
         gnt_owner = (last_q == HOST) ? FIT : HOST;
      end else if (f_req) begin
         gnt_owner = FIT;
      end
   end

   // Remember the last winner; reset favours the fitter on the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= HOST;
      end else if (en && gnt_valid) begin
         last_q <= gnt_owner;
      end
   end

   assign gnt_fit = (gnt_owner == FIT);

endmodule

// File: rtl/pca_mem_arbiter.sv
// Burst arbiter sharing one constant memory between host and fitter.
//
//   state | meaning
//   IDLE  | sample requests, latch owner/address/length/direction on grant
//   BURST | one memory beat per cycle, down-counter reaches zero on last beat
//   DONE  | owner's done pulse, last read data returned
module pca_mem_arbiter
   import pca_fit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              h_req,
   input  logic              h_rd_wr,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [3:0]        h_len,
   input  logic [DATA_W-1:0] h_wdata,
   output logic              h_ack,
   output logic              h_rvalid,
   output logic              h_done,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic [3:0]        f_len,
   output logic              f_ack,
   output logic              f_rvalid,
   output logic              f_done,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_rd_wr,
   output logic [ADDR_W-1:0] mem_add,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            state_q;
   state_t            state_d;
   owner_t            owner_q;
   logic              rd_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        cnt_q;
   logic              rd_pend_q;
   logic              gnt_valid;
   logic              gnt_fit;
   logic              grant_en;
   logic              beat;
   logic              done_c;
   logic              own_fit;

   assign grant_en = (state_q == IDLE);

   pca_rr_arb u_arb (
      .clk       (clk),
      .reset     (reset),
      .h_req     (h_req),
      .f_req     (f_req),
      .en        (grant_en),
      .gnt_valid (gnt_valid),
      .gnt_fit   (gnt_fit)
   );

   // State register plus the burst context latched at grant time.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= HOST;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= beat & rd_q;
         if (state_q == IDLE && gnt_valid) begin
            owner_q <= gnt_fit ? FIT : HOST;
            rd_q    <= gnt_fit ? 1'b1 : h_rd_wr;
            addr_q  <= gnt_fit ? f_addr : h_addr;
            cnt_q   <= gnt_fit ? f_len : h_len;
         end else if (state_q == BURST) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (cnt_q != 4'd0) begin
               cnt_q <= cnt_q - 4'd1;
            end
         end
      end
   end

   // Next-state decode and per-state strobes.
   always_comb begin
      state_d = state_q;
      beat    = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = BURST;
            end
         end
         BURST: begin
            beat = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign own_fit   = (owner_q == FIT);

   assign h_ack     = beat & ~own_fit;
   assign f_ack     = beat &  own_fit;
   assign h_done    = done_c & ~own_fit;
   assign f_done    = done_c &  own_fit;
   assign h_rvalid  = rd_pend_q & ~own_fit;
   assign f_rvalid  = rd_pend_q &  own_fit;
   assign rdata     = rd_pend_q ? mem_rdata : '0;

   assign mem_en    = beat;
   assign mem_rd_wr = beat & rd_q;
   assign mem_add   = beat ? addr_q : '0;
   // Only a host burst can be a write, so h_wdata is the sole write source.
   assign mem_wdata = (beat && !rd_q) ? h_wdata : '0;

   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pca_mem_arbiter.sv
// Scoreboard bench for pca_mem_arbiter: expected beats, read returns,
// done pulses and busy windows are queued with their cycle numbers when a
// request is driven, and a negedge monitor compares them every cycle.
module tb_pca_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        h_req = 1'b0;
   logic        h_rd_wr = 1'b0;
   logic [7:0]  h_addr = '0;
   logic [3:0]  h_len = '0;
   logic [31:0] h_wdata;
   logic        h_ack, h_rvalid, h_done;
   logic        f_req = 1'b0;
   logic [7:0]  f_addr = '0;
   logic [3:0]  f_len = '0;
   logic        f_ack, f_rvalid, f_done;
   logic [31:0] rdata;
   logic        mem_en, mem_rd_wr;
   logic [7:0]  mem_add;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {int cyc; logic [7:0] addr; logic rd; logic fit; logic [31:0] wd;} beat_t;
   typedef struct {int cyc; logic fit; logic [31:0] d;} ev_t;
   typedef struct {int lo; int hi;} win_t;

   beat_t bq[$];
   ev_t   rq[$];
   ev_t   dq[$];
   win_t  wq[$];

   pca_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .h_req     (h_req),
      .h_rd_wr   (h_rd_wr),
      .h_addr    (h_addr),
      .h_len     (h_len),
      .h_wdata   (h_wdata),
      .h_ack     (h_ack),
      .h_rvalid  (h_rvalid),
      .h_done    (h_done),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_len     (f_len),
      .f_ack     (f_ack),
      .f_rvalid  (f_rvalid),
      .f_done    (f_done),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_rd_wr (mem_rd_wr),
      .mem_add   (mem_add),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] wpat(input int c);
      return 32'hC0DE_0000 ^ 32'(c);
   endfunction

   function automatic logic [31:0] rpat(input logic [7:0] a);
      return 32'h5A00_0000 | (32'(a) * 32'h0000_0101);
   endfunction

   // Host write data changes every cycle so each beat has a distinct value.
   assign h_wdata = wpat(cyc);

   // Memory model: read data appears the cycle after a read strobe.
   always @(posedge clk) begin
      mem_rdata <= (mem_en && mem_rd_wr) ? rpat(mem_add) : 32'hDEAD_DEAD;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic go_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Queue the expected activity of a burst requested in cycle t.
   // cut > 0 models a burst killed by reset after that many beats.
   task automatic push_burst(input bit fit, input bit rd, input logic [7:0] a,
                             input int l, input int t, input int cut);
      int nb;
      beat_t b;
      ev_t   e;
      win_t  w;
      nb = (cut > 0) ? cut : l + 1;
      for (int i = 0; i < nb; i++) begin
         b.cyc  = t + 1 + i;
         b.addr = a + 8'(i);
         b.rd   = rd;
         b.fit  = fit;
         b.wd   = rd ? 32'h0 : wpat(t + 1 + i);
         bq.push_back(b);
         if (rd && cut == 0) begin
            e.cyc = t + 2 + i;
            e.fit = fit;
            e.d   = rpat(a + 8'(i));
            rq.push_back(e);
         end
      end
      if (cut == 0) begin
         e.cyc = t + l + 2;
         e.fit = fit;
         e.d   = '0;
         dq.push_back(e);
      end
      w.lo = t + 1;
      w.hi = (cut > 0) ? t + cut : t + l + 2;
      wq.push_back(w);
   endtask

   task automatic do_burst(input bit fit, input bit rd, input logic [7:0] a, input logic [3:0] l);
      int t;
      t = cyc;
      if (fit) begin
         f_req = 1'b1; f_addr = a; f_len = l;
      end else begin
         h_req = 1'b1; h_rd_wr = rd; h_addr = a; h_len = l;
      end
      push_burst(fit, fit ? 1'b1 : rd, a, int'(l), t, 0);
      go_cyc(t + int'(l) + 3);
      h_req = 1'b0;
      f_req = 1'b0;
   endtask

   // Per-cycle comparison of DUT outputs against the scoreboard heads.
   always @(negedge clk) begin
      beat_t b;
      ev_t   e;
      bit    exp_busy;
      if (cyc >= 1) begin
         if (bq.size() > 0 && bq[0].cyc == cyc) begin
            b = bq.pop_front();
            check("beat_en",  64'(mem_en), 64'd1);
            check("beat_add", 64'(mem_add), 64'(b.addr));
            check("beat_dir", 64'(mem_rd_wr), 64'(b.rd));
            check("beat_wd",  64'(mem_wdata), 64'(b.wd));
            check("beat_ack", 64'({h_ack, f_ack}), b.fit ? 64'd1 : 64'd2);
         end else begin
            check("idle_bus", 64'({mem_en, mem_wdata, h_ack, f_ack}), 64'd0);
         end
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            e = rq.pop_front();
            check("rvalid", 64'({h_rvalid, f_rvalid}), e.fit ? 64'd1 : 64'd2);
            check("rdata",  64'(rdata), 64'(e.d));
         end else begin
            check("rv_idle", 64'({h_rvalid, f_rvalid, rdata}), 64'd0);
         end
         if (dq.size() > 0 && dq[0].cyc == cyc) begin
            e = dq.pop_front();
            check("done", 64'({h_done, f_done}), e.fit ? 64'd1 : 64'd2);
         end else begin
            check("done_idle", 64'({h_done, f_done}), 64'd0);
         end
         while (wq.size() > 0 && wq[0].hi < cyc) void'(wq.pop_front());
         exp_busy = (wq.size() > 0 && wq[0].lo <= cyc);
         check("busy", 64'(busy), 64'(exp_busy));
      end
   end

   initial begin
      int t;
      go_cyc(3);
      reset = 1'b0;
      go_cyc(5);

      // Both requesting from reset, single-beat reads: F, H, F, H.
      t = cyc;
      h_req = 1'b1; h_rd_wr = 1'b1; h_addr = 8'h40; h_len = 4'd0;
      f_req = 1'b1; f_addr = 8'h80; f_len = 4'd0;
      push_burst(1'b1, 1'b1, 8'h80, 0, t,     0);
      push_burst(1'b0, 1'b1, 8'h40, 0, t + 3, 0);
      push_burst(1'b1, 1'b1, 8'h80, 0, t + 6, 0);
      push_burst(1'b0, 1'b1, 8'h40, 0, t + 9, 0);
      go_cyc(t + 12);
      h_req = 1'b0; f_req = 1'b0;
      go_cyc(cyc + 1);

      // Host write, 4 beats from 0x10.
      do_burst(1'b0, 1'b0, 8'h10, 4'd3);
      // Fitter read wrapping past 0xFF.
      do_burst(1'b1, 1'b1, 8'hFE, 4'd2);
      // Host read, 6 beats.
      do_burst(1'b0, 1'b1, 8'h33, 4'd5);
      // Fitter, 16-beat read wrapping.
      do_burst(1'b1, 1'b1, 8'hF8, 4'd15);

      // Fitter drops its request after two of eight beats.
      t = cyc;
      f_req = 1'b1; f_addr = 8'h20; f_len = 4'd7;
      push_burst(1'b1, 1'b1, 8'h20, 7, t, 0);
      go_cyc(t + 3);
      f_req = 1'b0;
      go_cyc(t + 10);

      // Reset lands during beat 3 of a 16-beat host write.
      t = cyc;
      h_req = 1'b1; h_rd_wr = 1'b0; h_addr = 8'h70; h_len = 4'd15;
      push_burst(1'b0, 1'b0, 8'h70, 15, t, 3);
      go_cyc(t + 3);
      reset = 1'b1; h_req = 1'b0;
      go_cyc(t + 5);
      reset = 1'b0;
      go_cyc(t + 6);

      // Last-grant is back to host after reset: fitter wins the tie again.
      t = cyc;
      h_req = 1'b1; h_rd_wr = 1'b0; h_addr = 8'h05; h_len = 4'd1;
      f_req = 1'b1; f_addr = 8'hA0; f_len = 4'd1;
      push_burst(1'b1, 1'b1, 8'hA0, 1, t,     0);
      push_burst(1'b0, 1'b0, 8'h05, 1, t + 4, 0);
      go_cyc(t + 8);
      h_req = 1'b0; f_req = 1'b0;

      go_cyc(cyc + 4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
